mem_resp_model: RTL and testbench
=================================

MEM_RESP_MODEL -- requirements
Module: mem_resp_model

Interface
REQ-001 SHALL have parameter MISS_LAT, default 6: accept-to-Done cycles on a miss; legal range 3..20.
REQ-002 SHALL have port clk, input, 1: the single clock. All state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port Addr, input, 16: byte address of the request; bit 0 is ignored.
REQ-005 SHALL have port DataIn, input, 16: write data.
REQ-006 SHALL have port Rd, input, 1: read request.
REQ-007 SHALL have port Wr, input, 1: write request.
REQ-008 SHALL have port createdump, input, 1: has no functional effect.
REQ-009 SHALL have port DataOut, output, 16: read data, valid only when Done=1.
REQ-010 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port Stall, output, 1: busy indication; the block refuses new requests while it is 1.
REQ-012 SHALL have port CacheHit, output, 1: hit status of the completing request, valid only when Done=1.

Function
REQ-013 SHALL accept a request in cycle N if exactly one of Rd/Wr is 1 and Stall=0, latching Addr, DataIn and the request type.
REQ-014 SHALL ignore Rd=Wr=1 as a non-request: no Done, no state change.
REQ-015 SHALL keep backing storage of 32K x 16 words, indexed by Addr[15:1], zero at simulation start and not cleared by rst.
REQ-016 SHALL commit a write to backing storage at the accept edge; a read SHALL return the storage value as of acceptance.
REQ-017 SHALL model a 2-way set-associative tag store with the following address split:
- tag = Addr[15:11] (5 bits)
- index = Addr[10:3] (256 sets)
- offset = Addr[2:0]
- per-way state: valid bit plus tag
REQ-018 SHALL declare a hit when either way at the index is valid with a matching tag; otherwise the request is a miss.
REQ-019 SHALL on a miss fill the victim way at the accept edge: way0 if invalid, else way1 if invalid, else the way selected by the victimway flop.
REQ-020 SHALL toggle victimway on every accepted request; its reset value is 0.
REQ-021 SHALL, on a hit, assert Done and CacheHit at N+1, with Stall=0 throughout.
REQ-022 SHALL, on a miss, hold Stall=1 for cycles N+1..N+MISS_LAT-1 and assert Done=1, CacheHit=0 and Stall=0 at N+MISS_LAT.
REQ-023 SHALL drive Done high for exactly one cycle per accepted request.
REQ-024 SHALL drive DataOut to 0 whenever Done=0 and on write completions.
REQ-025 SHALL accept a new request in the same cycle Done is high (back-to-back).
REQ-026 SHALL use FSM states IDLE, RESP and WAIT with these transitions:
- IDLE -> RESP on a hit accept
- IDLE -> WAIT on a miss accept
- WAIT -> RESP when the miss counter reaches MISS_LAT-1
- RESP -> RESP on an accept that hits; RESP -> WAIT on an accept that misses; otherwise RESP -> IDLE
REQ-027 SHALL saturate the 5-bit miss counter, which clears on each accept.

Reset
REQ-028 SHALL on rst drive DataOut=0, Done=0, Stall=0, CacheHit=0, FSM=IDLE, counter=0, victimway=0, and clear all valid bits.
REQ-029 SHALL on rst mid-operation drop the in-flight request with no Done; writes already committed SHALL remain in storage.

Structure
REQ-030 SHALL place the following in package mem_resp_pkg:
- FSM state typedef
- TAG_W=5, IDX_W=8, OFF_W=3
- DEF_MISS_LAT=6
REQ-031 SHALL instantiate one sub-module, mem_resp_tagstore, containing the valid/tag arrays, hit detection and the way-fill logic.

Verification
REQ-032 SHALL verify a cold miss: Wr 0x6010 with DataIn 0xBEEF accepted at cycle 20 -> Stall=1 in cycles 21-25; Done=1, CacheHit=0 at 26.
REQ-033 SHALL verify a hit: Rd 0x6010 after REQ-032 -> Done=1, CacheHit=1, DataOut=0xBEEF one cycle after accept.
REQ-034 SHALL verify eviction within set 2, tags 1, 2, 3:
- Rd 0x0810 -> miss
- Rd 0x1010 -> miss
- Rd 0x1810 -> miss, evicts the victim-selected way
- Rd 0x0810 again -> CacheHit equals whether that way survived per victimway
REQ-035 SHALL verify back-to-back operation: a new Rd presented in the Done cycle -> accepted with no idle cycle, and its Done follows at the correct latency.
REQ-036 SHALL verify illegal request and reset:
- Rd=Wr=1 held for 3 cycles -> no Done
- rst asserted at N+3 of a miss -> all outputs 0, no Done
- after rst, Rd of a previously hit address -> miss
REQ-037 SHALL verify the latency bound: with MISS_LAT=20, a miss -> Done exactly 20 cycles after accept.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Purpose: shared types and constants for the memory response model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

  localparam int TAG_W        = 5;  // Addr[15:11]
  localparam int IDX_W        = 8;  // Addr[10:3], 256 sets
  localparam int OFF_W        = 3;  // Addr[2:0]
  localparam int CNT_W        = 5;  // miss latency counter
  localparam int DEF_MISS_LAT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_tagstore.sv
// Purpose: 2-way set-associative tag store: hit detection, victim choice, fill.
// Latency: hit is combinational from tag/index; fill and victimway update on the accept edge.
// Backpressure: none; the caller only pulses accept when it is taking a request.
// Ports: clk/rst (async active-high); tag, index of the presented request;
//        accept = request taken this cycle; hit = either way valid with matching tag.
module mem_resp_tagstore
  import mem_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag,
  input  logic [IDX_W-1:0] index,
  input  logic             accept,
  output logic             hit
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]  valid0;
  logic [SETS-1:0]  valid1;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic             victimway;
  logic             hit0;
  logic             hit1;
  logic             fill;
  logic             fill_way;

  assign hit0 = valid0[index] && (tag0[index] == tag);
  assign hit1 = valid1[index] && (tag1[index] == tag);
  assign hit  = hit0 || hit1;
  assign fill = accept && !hit;

  // Prefer an empty way; only fall back to the round-robin flop when the set is full.
  always_comb begin
    fill_way = victimway;
    if (!valid0[index]) begin
      fill_way = 1'b0;
    end else if (!valid1[index]) begin
      fill_way = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0    <= '0;
      valid1    <= '0;
      victimway <= 1'b0;
    end else begin
      if (accept) begin
        victimway <= ~victimway;
      end
      if (fill) begin
        if (fill_way) begin
          valid1[index] <= 1'b1;
        end else begin
          valid0[index] <= 1'b1;
        end
      end
    end
  end

  // Tags are only meaningful under their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (fill_way) begin
        tag1[index] <= tag;
      end else begin
        tag0[index] <= tag;
      end
    end
  end

endmodule

// File: rtl/mem_resp_model.sv
// Purpose: cycle-level memory/cache response model with 32K x 16 backing store.
// Latency: hit -> Done one cycle after accept; miss -> Done MISS_LAT cycles after accept.
// Backpressure: Stall=1 while a miss is outstanding; requests are refused, not queued.
// Ports: clk, rst (async active-high); Addr (bit 0 ignored), DataIn, Rd, Wr request
//        inputs; createdump unused; DataOut/CacheHit qualified by the Done pulse; Stall busy.
module mem_resp_model
  import mem_resp_pkg::*;
#(
  parameter int MISS_LAT = DEF_MISS_LAT  // legal range 3..20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             hit;
  logic             hit_q;
  logic [15:0]      rdata_q;
  logic             unused_ok;

  // Backing store survives rst; it starts zeroed and is changed only by writes.
  logic [15:0] mem [1 << 15] = '{default: '0};

  assign unused_ok = ^{createdump, Addr[0]};

  assign Stall  = (state == WAIT);
  // Rd=Wr=1 is not a request at all.
  assign accept = (Rd ^ Wr) && !Stall;

  mem_resp_tagstore u_tagstore (
    .clk    (clk),
    .rst    (rst),
    .tag    (Addr[15 -: TAG_W]),
    .index  (Addr[OFF_W +: IDX_W]),
    .accept (accept),
    .hit    (hit)
  );

  // Counter sits at 0 in the first WAIT cycle; leaving WAIT when the incremented
  // value hits MISS_LAT-1 places Done exactly MISS_LAT cycles after accept.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nxt = hit ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt_inc == CNT_W'(MISS_LAT - 1)) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        hit_q   <= hit;
        // Read data is captured at accept so a later write cannot alter it.
        rdata_q <= Rd ? mem[Addr[15:1]] : 16'h0000;
      end else if (state == WAIT) begin
        cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && Wr) begin
      mem[Addr[15:1]] <= DataIn;
    end
  end

  assign Done     = (state == RESP);
  assign CacheHit = Done && hit_q;
  assign DataOut  = Done ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_resp_model.sv
module tb_mem_resp_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;

  logic        rst20;
  logic [15:0] Addr20;
  logic [15:0] DataIn20;
  logic        Rd20;
  logic        Wr20;
  logic [15:0] DataOut20;
  logic        Done20;
  logic        Stall20;
  logic        CacheHit20;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_resp_model dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit)
  );

  mem_resp_model #(.MISS_LAT(20)) dut20 (
    .clk(clk), .rst(rst20), .Addr(Addr20), .DataIn(DataIn20), .Rd(Rd20), .Wr(Wr20),
    .createdump(1'b0), .DataOut(DataOut20), .Done(Done20), .Stall(Stall20),
    .CacheHit(CacheHit20)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    Rd     = rd;
    Wr     = wr;
    Addr   = a;
    DataIn = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst20 = 1'b1; createdump = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    Addr20 = 16'h0000; DataIn20 = 16'h0000; Rd20 = 1'b0; Wr20 = 1'b0;
    tick; tick;
    checks++;
    if ({DataOut, Done, Stall, CacheHit} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {DataOut, Done, Stall, CacheHit});
    end
    rst = 1'b0; rst20 = 1'b0;
    tick;
    checks++;
    if ({DataOut, Done, Stall, CacheHit} !== 19'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected 0", {DataOut, Done, Stall, CacheHit});
    end
    checks++;
    if ({DataOut20, Done20, Stall20, CacheHit20} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs_lat20: got %h expected 0", {DataOut20, Done20, Stall20, CacheHit20});
    end
  endtask

  // Wr 0x6010 presented in cycle 20: Stall in 21..25, Done in 26.
  task automatic test_cold_miss;
    while (cyc < 20) tick;
    drive(1'b0, 1'b1, 16'h6010, 16'hBEEF);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 21; k <= 25; k++) begin
      checks++;
      if (Stall !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL cold_miss_stall: cycle %0d got stall=%b done=%b expected stall=1 done=0", cyc, Stall, Done);
      end
      tick;
    end
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b0 || Stall !== 1'b0 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL cold_miss_done: got done=%b hit=%b stall=%b data=%h expected 1 0 0 0000",
               Done, CacheHit, Stall, DataOut);
    end
    checks++;
    if (cyc !== 26) begin
      errors++;
      $display("FAIL cold_miss_cycle: got %0d expected 26", cyc);
    end
    tick;
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL cold_miss_pulse: got done=%b expected 0", Done);
    end
  endtask

  task automatic test_hit;
    drive(1'b1, 1'b0, 16'h6010, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b1 || DataOut !== 16'hBEEF || Stall !== 1'b0) begin
      errors++;
      $display("FAIL hit_read: got done=%b hit=%b data=%h stall=%b expected 1 1 beef 0",
               Done, CacheHit, DataOut, Stall);
    end
    tick;
    checks++;
    if (Done !== 1'b0 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL hit_pulse: got done=%b data=%h expected 0 0000", Done, DataOut);
    end
  endtask

  // Set 2 holds tag 12 in way0, victimway=0 on entry. Walk-through:
  // 0810 -> way1, 1010 evicts way1 (vw=1), 1810 evicts way0 (vw=0),
  // 0810 misses (tag 1 was evicted), 1810 hits in way0.
  task automatic test_eviction;
    logic [15:0] ev_addr [5];
    logic        ev_hit  [5];
    int          lat;
    ev_addr = '{16'h0810, 16'h1010, 16'h1810, 16'h0810, 16'h1810};
    ev_hit  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, ev_addr[i], 16'h0000);
      tick;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      lat = 1;
      while (Done !== 1'b1 && lat < 40) begin
        tick;
        lat++;
      end
      checks++;
      if (lat !== (ev_hit[i] ? 1 : 6) || CacheHit !== ev_hit[i] || DataOut !== 16'h0000) begin
        errors++;
        $display("FAIL evict_step%0d: addr %h got lat=%0d hit=%b data=%h expected lat=%0d hit=%b data=0000",
                 i, ev_addr[i], lat, CacheHit, DataOut, ev_hit[i] ? 1 : 6, ev_hit[i]);
      end
      tick;
    end
  endtask

  // Set 2: way0=3, way1=1, victimway=1. Chain hit -> hit -> miss -> hit with
  // each next request presented in the previous Done cycle.
  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 16'h1810, 16'h0000);
    tick;
    drive(1'b1, 1'b0, 16'h0810, 16'h0000);
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got done=%b hit=%b expected 1 1", Done, CacheHit);
    end
    tick;
    drive(1'b1, 1'b0, 16'h6010, 16'h0000);
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b1 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got done=%b hit=%b stall=%b expected 1 1 0", Done, CacheHit, Stall);
    end
    tick;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (Stall !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_miss_stall: wait %0d got stall=%b done=%b expected 1 0", k, Stall, Done);
      end
      tick;
    end
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b0 || DataOut !== 16'hBEEF) begin
      errors++;
      $display("FAIL b2b_miss_done: got done=%b hit=%b data=%h expected 1 0 beef", Done, CacheHit, DataOut);
    end
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++;
    if (Done !== 1'b1 || CacheHit !== 1'b1 || DataOut !== 16'hBEEF) begin
      errors++;
      $display("FAIL b2b_after_miss: got done=%b hit=%b data=%h expected 1 1 beef", Done, CacheHit, DataOut);
    end
    tick;
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got done=%b expected 0", Done);
    end
  endtask

  // Set 2: way0=3, way1=12, victimway=1. Rd=Wr=1 must neither complete nor
  // write 0x5555, so a following Rd 0x1010 is a plain miss returning 0.
  task automatic test_illegal;
    int lat;
    drive(1'b1, 1'b1, 16'h1010, 16'h5555);
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (Done !== 1'b0 || Stall !== 1'b0) begin
        errors++;
        $display("FAIL illegal_req: cycle %0d got done=%b stall=%b expected 0 0", k, Done, Stall);
      end
    end
    drive(1'b1, 1'b0, 16'h1010, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    checks++;
    if (lat !== 6 || CacheHit !== 1'b0 || DataOut !== 16'h0000) begin
      errors++;
      $display("FAIL illegal_no_effect: got lat=%0d hit=%b data=%h expected 6 0 0000", lat, CacheHit, DataOut);
    end
    tick;
  endtask

  task automatic test_reset_midflight;
    int lat;
    int done_seen;
    drive(1'b0, 1'b1, 16'h2010, 16'h1234);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick; tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({DataOut, Done, Stall, CacheHit} !== 19'h0) begin
      errors++;
      $display("FAIL midflight_reset_outputs: got %h expected 0", {DataOut, Done, Stall, CacheHit});
    end
    tick;
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (Done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL midflight_no_done: got %0d done pulses expected 0", done_seen);
    end
    // 0x6010 hit before reset; valid bits are gone so it misses now, data kept.
    drive(1'b1, 1'b0, 16'h6010, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    checks++;
    if (lat !== 6 || CacheHit !== 1'b0 || DataOut !== 16'hBEEF) begin
      errors++;
      $display("FAIL post_reset_miss: got lat=%0d hit=%b data=%h expected 6 0 beef", lat, CacheHit, DataOut);
    end
    tick;
    // The write dropped by reset had already committed at its accept edge.
    drive(1'b1, 1'b0, 16'h2010, 16'h0000);
    tick;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    checks++;
    if (lat !== 6 || CacheHit !== 1'b0 || DataOut !== 16'h1234) begin
      errors++;
      $display("FAIL committed_write: got lat=%0d hit=%b data=%h expected 6 0 1234", lat, CacheHit, DataOut);
    end
    tick;
  endtask

  task automatic test_lat20;
    int lat;
    int stall_bad;
    Addr20 = 16'h4000;
    Rd20   = 1'b1;
    tick;
    Rd20   = 1'b0;
    lat       = 1;
    stall_bad = 0;
    while (Done20 !== 1'b1 && lat < 40) begin
      if (Stall20 !== 1'b1) stall_bad++;
      tick;
      lat++;
    end
    checks++;
    if (lat !== 20 || CacheHit20 !== 1'b0 || Stall20 !== 1'b0) begin
      errors++;
      $display("FAIL lat20_done: got lat=%0d hit=%b stall=%b expected 20 0 0", lat, CacheHit20, Stall20);
    end
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL lat20_stall: got %0d non-stall wait cycles expected 0", stall_bad);
    end
    tick;
    checks++;
    if (Done20 !== 1'b0) begin
      errors++;
      $display("FAIL lat20_pulse: got done=%b expected 0", Done20);
    end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_eviction;
    test_back_to_back;
    test_illegal;
    test_reset_midflight;
    test_lat20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
